// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and counter width.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MAX_WIDTH = 32;
    // Sized for the widest legal operand so one counter type serves every WIDTH.
    localparam int CW = $clog2(MAX_WIDTH);

endpackage

// File: rtl/cla_subtractor.sv
// WIDTH-bit subtractor a - b, computed as a + ~b + 1 through chained 8-bit carry-lookahead slices.
module cla_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             no_borrow
);

    localparam int SLICES = WIDTH / 8;

    logic [WIDTH-1:0] b_n;
    assign b_n = ~b;

    for (genvar s = 0; s < SLICES; s++) begin : g_slice
        logic       cin;
        logic       cout;
        logic [7:0] g;
        logic [7:0] p;
        logic [8:0] cc;

        if (s == 0) begin : g_first
            assign cin = 1'b1;
        end else begin : g_chain
            assign cin = g_slice[s-1].cout;
        end

        // Each carry is a flat group-generate/propagate term of the slice inputs plus cin.
        always_comb begin
            logic gg;
            logic pp;
            g     = a[s*8 +: 8] & b_n[s*8 +: 8];
            p     = a[s*8 +: 8] ^ b_n[s*8 +: 8];
            cc    = '0;
            cc[0] = cin;
            for (int i = 0; i < 8; i++) begin
                gg = 1'b0;
                pp = 1'b1;
                for (int j = 0; j <= i; j++) begin
                    gg = g[j] | (p[j] & gg);
                    pp = pp & p[j];
                end
                cc[i+1] = gg | (pp & cin);
            end
        end

        assign diff[s*8 +: 8] = p ^ cc[7:0];
        assign cout           = cc[8];
    end

    assign no_borrow = g_slice[SLICES-1].cout;

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle, valid/ready on both sides.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            out_valid_q, out_valid_d;
    logic            dbz_q, dbz_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    // The partial remainder's top bit is always 0 after an iteration, so only WIDTH bits are kept.
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;

    logic [WIDTH:0]   rs;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;
    logic             take;

    assign rs   = {r_q, q_q[WIDTH-1]};
    assign take = rs[WIDTH] | no_borrow;

    cla_subtractor #(.WIDTH(WIDTH)) u_sub (
        .a         (rs[WIDTH-1:0]),
        .b         (d_q),
        .diff      (diff),
        .no_borrow (no_borrow)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        dbz_d       = dbz_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        q_d         = q_q;
        r_d         = r_q;
        d_d         = d_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    d_d     = divisor;
                    q_d     = dividend;
                    r_d     = '0;
                    count_d = '0;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        quot_d      = '1;
                        rem_d       = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = BUSY;
                        dbz_d   = 1'b0;
                    end
                end
            end
            BUSY: begin
                // Rs[WIDTH]=1 means Rs already exceeds any D, so the truncated diff is exact.
                r_d     = take ? diff : rs[WIDTH-1:0];
                q_d     = {q_q[WIDTH-2:0], take};
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    quot_d      = q_d;
                    rem_d       = r_d;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            dbz_q       <= dbz_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
        end
    end

    // Working registers are always reloaded at accept, so they carry no reset.
    always_ff @(posedge clk) begin
        q_q <= q_d;
        r_q <= r_d;
        d_q <= d_d;
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider at WIDTH 8, 16 and 32 against an arithmetic reference model.
module tb_seq_restoring_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid [3];
    logic        out_ready[3];
    logic [31:0] dvd[3];
    logic [31:0] dvs[3];

    wire [2:0]  in_ready_w;
    wire [2:0]  out_valid_w;
    wire [2:0]  dbz_w;
    wire [7:0]  q8,  r8;
    wire [15:0] q16, r16;
    wire [31:0] q32, r32;

    int checks   = 0;
    int failures = 0;

    seq_restoring_divider #(.WIDTH(8)) u_div8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
        .dividend(dvd[0][7:0]), .divisor(dvs[0][7:0]), .out_valid(out_valid_w[0]),
        .out_ready(out_ready[0]), .quotient(q8), .remainder(r8), .div_by_zero(dbz_w[0])
    );

    seq_restoring_divider #(.WIDTH(16)) u_div16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
        .dividend(dvd[1][15:0]), .divisor(dvs[1][15:0]), .out_valid(out_valid_w[1]),
        .out_ready(out_ready[1]), .quotient(q16), .remainder(r16), .div_by_zero(dbz_w[1])
    );

    seq_restoring_divider #(.WIDTH(32)) u_div32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
        .dividend(dvd[2]), .divisor(dvs[2]), .out_valid(out_valid_w[2]),
        .out_ready(out_ready[2]), .quotient(q32), .remainder(r32), .div_by_zero(dbz_w[2])
    );

    function automatic int wof(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 16 : 32);
    endfunction

    function automatic logic [31:0] mask_of(input int i);
        return (i == 0) ? 32'h0000_00FF : ((i == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] q_of(input int i);
        return (i == 0) ? {24'h0, q8} : ((i == 1) ? {16'h0, q16} : q32);
    endfunction

    function automatic logic [31:0] r_of(input int i);
        return (i == 0) ? {24'h0, r8} : ((i == 1) ? {16'h0, r16} : r32);
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    task automatic model(input int i, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output int lat);
        if (b == 0) begin
            q = mask_of(i); r = a; dz = 1'b1; lat = 1;
        end else begin
            q = a / b; r = a % b; dz = 1'b0; lat = wof(i);
        end
    endtask

    task automatic start_op(input int i, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        for (int n = 0; n < 100 && !in_ready_w[i]; n++) @(negedge clk);
        in_valid[i] = 1'b1;
        dvd[i] = a;
        dvs[i] = b;
        @(posedge clk);
        #1 in_valid[i] = 1'b0;
    endtask

    task automatic wait_result(input int i, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        repeat (80) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid_w[i]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic retire(input int i);
        @(negedge clk);
        out_ready[i] = 1'b1;
        @(posedge clk);
        #1 out_ready[i] = 1'b0;
    endtask

    task automatic run_check(input int i, input logic [31:0] a_in, input logic [31:0] b_in,
                             input string tag);
        logic [31:0] a, b, eq, er;
        logic        edz;
        int          elat, lat;
        bit          ok;
        a = a_in & mask_of(i);
        b = b_in & mask_of(i);
        model(i, a, b, eq, er, edz, elat);
        start_op(i, a, b);
        wait_result(i, lat, ok);
        if (!ok) begin
            chk({tag, "_timeout"}, 64'(ok), 64'd1);
            return;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_q"}, 64'(q_of(i)), 64'(eq));
        chk({tag, "_r"}, 64'(r_of(i)), 64'(er));
        chk({tag, "_dbz"}, 64'(dbz_w[i]), 64'(edz));
        retire(i);
        chk({tag, "_ready_after"}, 64'(in_ready_w[i]), 64'd1);
        chk({tag, "_valid_after"}, 64'(out_valid_w[i]), 64'd0);
    endtask

    function automatic logic [31:0] rnd_operand(input int i);
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h1;
            3:       v = 32'($urandom_range(0, 15));
            4:       v = $urandom | (32'h1 << (wof(i) - 1));
            default: v = $urandom;
        endcase
        return v & mask_of(i);
    endfunction

    task automatic sweep(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            run_check(i, rnd_operand(i), rnd_operand(i), "rnd");
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] q_hold, r_hold;
        int          lat;
        bit          ok;
        int          ghost;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0; dvd[i] = '0; dvs[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", 64'(in_ready_w[i]), 64'd1);
            chk("rst_out_valid", 64'(out_valid_w[i]), 64'd0);
            chk("rst_q", 64'(q_of(i)), 64'd0);
            chk("rst_r", 64'(r_of(i)), 64'd0);
            chk("rst_dbz", 64'(dbz_w[i]), 64'd0);
        end
        rst_n = 1'b1;

        run_check(2, 32'd100, 32'd7, "d100_7");
        run_check(2, 32'hFFFF_FFFF, 32'h8000_0001, "msb_path");
        run_check(2, 32'd3, 32'd10, "small_num");
        run_check(2, 32'd5, 32'd0, "div0");
        run_check(2, 32'd9, 32'd3, "after_div0");
        run_check(2, 32'hCAFE_F00D, 32'd1, "div_one");
        run_check(0, 32'hFF, 32'h81, "msb8");
        run_check(1, 32'hFFFF, 32'h8001, "msb16");

        // Backpressure: result must hold and new requests must be ignored.
        start_op(2, 32'h1234_5678, 32'h0000_1234);
        wait_result(2, lat, ok);
        chk("bp_valid", 64'(ok), 64'd1);
        q_hold = q32;
        r_hold = r32;
        chk("bp_q", 64'(q_hold), 64'(32'h1234_5678 / 32'h1234));
        chk("bp_r", 64'(r_hold), 64'(32'h1234_5678 % 32'h1234));
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            in_valid[2] = n[0];
            dvd[2] = $urandom;
            dvs[2] = $urandom;
            chk("bp_q_stable", 64'(q32), 64'(q_hold));
            chk("bp_r_stable", 64'(r32), 64'(r_hold));
            chk("bp_in_ready", 64'(in_ready_w[2]), 64'd0);
            chk("bp_out_valid", 64'(out_valid_w[2]), 64'd1);
        end
        @(negedge clk);
        in_valid[2] = 1'b0;
        retire(2);
        chk("bp_retired", 64'(out_valid_w[2]), 64'd0);
        chk("bp_ready_next", 64'(in_ready_w[2]), 64'd1);
        ghost = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_w[2] || !in_ready_w[2]) ghost++;
        end
        chk("bp_no_ghost_op", 64'(ghost), 64'd0);

        // Asynchronous reset in the middle of an operation.
        start_op(2, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_q", 64'(q32), 64'd0);
        chk("mid_rst_r", 64'(r32), 64'd0);
        chk("mid_rst_dbz", 64'(dbz_w[2]), 64'd0);
        chk("mid_rst_valid", 64'(out_valid_w[2]), 64'd0);
        chk("mid_rst_ready", 64'(in_ready_w[2]), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        ghost = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_w[2]) ghost++;
        end
        chk("mid_rst_discarded", 64'(ghost), 64'd0);
        run_check(2, 32'hDEAD_BEEF, 32'h0000_1234, "after_rst");

        fork
            sweep(0, 2500);
            sweep(1, 1800);
            sweep(2, 1000);
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
